// File: rtl/uni_shift_reg_seq.sv
`default_nettype none
// ============================================================================
// Module      : uni_shift_reg_seq
// Description : Parametrised universal shift register with multi-step
//               shift/rotate/ASR commands and a start/busy/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module uni_shift_reg_seq #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       mode,
  input  logic             start,
  input  logic [AMT_W-1:0] amount,
  input  logic             MSB_in,
  input  logic             LSB_in,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic             shift_out,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] c_MODE_HOLD  = 3'b000;
  localparam logic [2:0] c_MODE_SHR   = 3'b001;
  localparam logic [2:0] c_MODE_SHL   = 3'b010;
  localparam logic [2:0] c_MODE_LOAD  = 3'b011;
  localparam logic [2:0] c_MODE_ROR   = 3'b100;
  localparam logic [2:0] c_MODE_ROL   = 3'b101;
  localparam logic [2:0] c_MODE_ASR   = 3'b110;
  localparam logic [2:0] c_MODE_CLEAR = 3'b111;

  localparam logic [AMT_W-1:0] c_AMT_ZERO = '0;
  localparam logic [AMT_W-1:0] c_AMT_ONE  = {{(AMT_W-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           r_state;
  logic [AMT_W-1:0] r_count;
  logic [2:0]       r_mode;

  logic [2:0]       w_step_mode;
  logic [WIDTH-1:0] w_step_val;
  logic             w_step_bit;

  // One single-bit step of the active command; the latched mode drives RUN.
  always_comb begin
    w_step_mode = (r_state == S_RUN) ? r_mode : mode;
    w_step_val  = out;
    w_step_bit  = shift_out;
    case (w_step_mode)
      c_MODE_SHR: begin
        w_step_val = {MSB_in, out[WIDTH-1:1]};
        w_step_bit = out[0];
      end
      c_MODE_SHL: begin
        w_step_val = {out[WIDTH-2:0], LSB_in};
        w_step_bit = out[WIDTH-1];
      end
      c_MODE_ROR: begin
        w_step_val = {out[0], out[WIDTH-1:1]};
        w_step_bit = out[0];
      end
      c_MODE_ROL: begin
        w_step_val = {out[WIDTH-2:0], out[WIDTH-1]};
        w_step_bit = out[WIDTH-1];
      end
      c_MODE_ASR: begin
        w_step_val = {out[WIDTH-1], out[WIDTH-1:1]};
        w_step_bit = out[0];
      end
      default: begin
        w_step_val = out;
        w_step_bit = shift_out;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_count   <= '0;
      r_mode    <= c_MODE_HOLD;
      out       <= '0;
      shift_out <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            case (mode)
              c_MODE_HOLD: done <= 1'b1;
              c_MODE_LOAD: begin
                out  <= in;
                done <= 1'b1;
              end
              c_MODE_CLEAR: begin
                out  <= '0;
                done <= 1'b1;
              end
              default: begin
                // First step happens on the accepting edge itself.
                if (amount != c_AMT_ZERO) begin
                  out       <= w_step_val;
                  shift_out <= w_step_bit;
                end
                if (amount > c_AMT_ONE) begin
                  r_state <= S_RUN;
                  busy    <= 1'b1;
                  r_count <= amount - c_AMT_ONE;
                  r_mode  <= mode;
                end else begin
                  done <= 1'b1;
                end
              end
            endcase
          end
        end
        S_RUN: begin
          out       <= w_step_val;
          shift_out <= w_step_bit;
          r_count   <= r_count - c_AMT_ONE;
          if (r_count == c_AMT_ONE) begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uni_shift_reg_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_uni_shift_reg_seq
// Description : Self-checking bench: cycle model plus directed literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uni_shift_reg_seq;
  localparam int W = 8;
  localparam int A = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [2:0]   mode = 3'b000;
  logic         start = 1'b0;
  logic [A-1:0] amount = '0;
  logic         MSB_in = 1'b0;
  logic         LSB_in = 1'b0;
  logic [W-1:0] in = '0;
  logic [W-1:0] out;
  logic         shift_out;
  logic         busy;
  logic         done;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  uni_shift_reg_seq #(.WIDTH(W), .AMT_W(A)) dut (
    .clk(clk), .reset(reset), .mode(mode), .start(start), .amount(amount),
    .MSB_in(MSB_in), .LSB_in(LSB_in), .in(in), .out(out),
    .shift_out(shift_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Reference model: remaining-step count plus the current register image.
  logic [W-1:0] m_out = '0;
  logic         m_so = 1'b0;
  logic         m_done = 1'b0;
  int           m_rem = 0;
  logic [2:0]   m_mode = 3'b000;

  function automatic logic [W:0] step1(input logic [2:0] m, input logic [W-1:0] v,
                                       input logic so, input logic msb, input logic lsb);
    logic [W-1:0] r;
    logic         b;
    r = v;
    b = so;
    case (m)
      3'd1: begin r = (v >> 1) | (W'(msb) << (W-1)); b = v[0]; end
      3'd2: begin r = (v << 1) | W'(lsb);            b = v[W-1]; end
      3'd4: begin r = (v >> 1) | (W'(v[0]) << (W-1)); b = v[0]; end
      3'd5: begin r = (v << 1) | W'(v[W-1]);          b = v[W-1]; end
      3'd6: begin r = W'($signed(v) >>> 1);           b = v[0]; end
      default: begin r = v; b = so; end
    endcase
    return {b, r};
  endfunction

  always @(posedge clk) begin
    logic [W:0] t;
    if (reset) begin
      m_out = '0; m_so = 1'b0; m_done = 1'b0; m_rem = 0;
    end else begin
      m_done = 1'b0;
      if (m_rem > 0) begin
        t = step1(m_mode, m_out, m_so, MSB_in, LSB_in);
        {m_so, m_out} = t;
        m_rem = m_rem - 1;
        if (m_rem == 0) m_done = 1'b1;
      end else if (start) begin
        if (mode == 3'd0) m_done = 1'b1;
        else if (mode == 3'd3) begin m_out = in; m_done = 1'b1; end
        else if (mode == 3'd7) begin m_out = '0; m_done = 1'b1; end
        else if (amount == 0) m_done = 1'b1;
        else begin
          m_mode = mode;
          t = step1(mode, m_out, m_so, MSB_in, LSB_in);
          {m_so, m_out} = t;
          m_rem = int'(amount) - 1;
          if (m_rem == 0) m_done = 1'b1;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      check("model_out", 32'(out), 32'(m_out));
      check("model_shift_out", 32'(shift_out), 32'(m_so));
      check("model_busy", 32'(busy), 32'(m_rem > 0));
      check("model_done", 32'(done), 32'(m_done));
    end
  end

  task automatic issue(input logic [2:0] m, input logic [A-1:0] a, input logic [W-1:0] d);
    @(negedge clk);
    mode = m; amount = a; in = d; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at a negedge just after the accepting edge.
  task automatic wait_done(output int bcyc);
    bit seen;
    bcyc = 0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (busy) bcyc++;
      if (done) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    check("done_seen", 32'(seen), 32'd1);
  endtask

  int bc;
  int dcount;

  initial begin
    reset = 1'b1;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    chk_en = 1'b1;
    check("reset_out", 32'(out), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);

    issue(3'b011, 4'd0, 8'hA5);
    wait_done(bc);
    check("load_out", 32'(out), 32'hA5);
    check("load_busy_cycles", 32'(bc), 32'd0);

    MSB_in = 1'b1;
    issue(3'b001, 4'd3, 8'h00);
    wait_done(bc);
    check("shr3_out", 32'(out), 32'hF4);
    check("shr3_so", 32'(shift_out), 32'd1);
    check("shr3_busy_cycles", 32'(bc), 32'd2);
    MSB_in = 1'b0;

    issue(3'b011, 4'd0, 8'hA5);
    wait_done(bc);
    issue(3'b101, 4'd4, 8'h00);
    wait_done(bc);
    check("rol4_out", 32'(out), 32'h5A);
    check("rol4_busy_cycles", 32'(bc), 32'd3);

    issue(3'b011, 4'd0, 8'h96);
    wait_done(bc);
    issue(3'b110, 4'd2, 8'h00);
    wait_done(bc);
    check("asr2_out", 32'(out), 32'hE5);
    check("asr2_so", 32'(shift_out), 32'd1);

    issue(3'b001, 4'd0, 8'h00);
    wait_done(bc);
    check("shr0_out", 32'(out), 32'hE5);
    check("shr0_busy_cycles", 32'(bc), 32'd0);

    issue(3'b011, 4'd0, 8'h3C);
    wait_done(bc);
    issue(3'b100, 4'd8, 8'h00);
    wait_done(bc);
    check("ror8_out", 32'(out), 32'h3C);

    LSB_in = 1'b0;
    issue(3'b010, 4'd15, 8'h00);
    wait_done(bc);
    check("shl15_out", 32'(out), 32'h00);
    check("shl15_busy_cycles", 32'(bc), 32'd14);

    // Start while busy: a load pulse mid-rotate must be ignored.
    issue(3'b011, 4'd0, 8'hA5);
    wait_done(bc);
    issue(3'b100, 4'd5, 8'h00);
    mode = 3'b011; in = 8'hFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(bc);
    check("ror5_ignore_out", 32'(out), 32'h2D);
    dcount = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done) dcount++;
    end
    check("ror5_single_done", 32'(dcount), 32'd0);

    // Reset mid-operation.
    issue(3'b011, 4'd0, 8'hFF);
    wait_done(bc);
    LSB_in = 1'b1;
    issue(3'b010, 4'd10, 8'h00);
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midreset_out", 32'(out), 32'h0);
    check("midreset_busy", 32'(busy), 32'd0);
    check("midreset_done", 32'(done), 32'd0);
    check("midreset_so", 32'(shift_out), 32'd0);
    issue(3'b011, 4'd0, 8'h5A);
    wait_done(bc);
    check("after_reset_load", 32'(out), 32'h5A);

    // Randomised traffic checked cycle by cycle against the model.
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      mode   = 3'($urandom_range(0, 7));
      amount = A'($urandom_range(0, (1 << A) - 1));
      in     = W'($urandom);
      MSB_in = 1'($urandom);
      LSB_in = 1'($urandom);
      start  = ($urandom_range(0, 2) == 0);
      reset  = ($urandom_range(0, 99) == 0);
    end
    @(negedge clk);
    start = 1'b0; reset = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
